// File: rtl/bram_lut_loader_if.sv
// bram_lut_loader_if: groups the byte-stream handshake and the BRAM port A
// signals of the LUT loader.
// The master modport is the loader side and the slave modport is the
// source/BRAM side.
interface bram_lut_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;

  modport master (
    input  s_valid, s_data, douta,
    output s_ready, ena, wea, addra, dina
  );

  modport slave (
    output s_valid, s_data, douta,
    input  s_ready, ena, wea, addra, dina
  );
endinterface

// File: rtl/bram_lut_loader.sv
// bram_lut_loader: takes a byte stream over valid/ready and writes it
// sequentially into a single-port BRAM, starting at base_addr with
// address wrap.
// A one-cycle done pulse marks completion.
//
// Optional build macro: LUT_LOADER_VERIFY_EN.
// When it is defined, the loader reads the loaded range back after the
// writes, compares modulo-2**DATA_W sums of the written and read bytes,
// and reports the result on err.
// Without it, err is tied low and douta is ignored.
module bram_lut_loader #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  bram_lut_loader_if.master lut_bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   C_LEN_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   C_LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

`ifdef LUT_LOADER_VERIFY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_FINISH = 2'd2,
    S_VERIFY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_FINISH = 2'd2
  } state_t;
`endif

  state_t            r_state, w_state_nxt;

  logic              r_s_ready, w_s_ready_nxt;
  logic              r_ena, w_ena_nxt;
  logic              r_wea, w_wea_nxt;
  logic [ADDR_W-1:0] r_addra, w_addra_nxt;
  logic [DATA_W-1:0] r_dina, w_dina_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  // Next BRAM address to use and beats still to accept.
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W:0]   r_left, w_left_nxt;
  logic              w_accept;

`ifdef LUT_LOADER_VERIFY_EN
  logic [ADDR_W-1:0]       r_base, w_base_nxt;
  logic [ADDR_W:0]         r_len, w_len_nxt;
  logic [DATA_W-1:0]       r_sum_w, w_sum_w_nxt;
  logic [DATA_W-1:0]       r_sum_r, w_sum_r_nxt;
  logic [ADDR_W:0]         r_rd_left, w_rd_left_nxt;
  logic [ADDR_W:0]         r_smp_left, w_smp_left_nxt;
  logic                    r_err, w_err_nxt;
  // Bit k is set when douta carries a requested read word k+1 cycles
  // after its strobe.
  logic [READ_LATENCY-1:0] r_rd_pipe;

  // The checksum is a plain modulo-2**DATA_W byte sum.
  function automatic logic [DATA_W-1:0] f_sum_add(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] val
  );
    return acc + val;
  endfunction
`else
  wire w_unused_douta = (^lut_bus.douta) ^ READ_LATENCY[0];
`endif

  assign w_accept = r_s_ready & lut_bus.s_valid;

  // Next-state and next-output logic for the load sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_s_ready_nxt = r_s_ready;
    w_ena_nxt     = 1'b0;
    w_wea_nxt     = 1'b0;
    w_addra_nxt   = r_addra;
    w_dina_nxt    = r_dina;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_addr_nxt    = r_addr;
    w_left_nxt    = r_left;
`ifdef LUT_LOADER_VERIFY_EN
    w_base_nxt     = r_base;
    w_len_nxt      = r_len;
    w_sum_w_nxt    = r_sum_w;
    w_sum_r_nxt    = r_sum_r;
    w_rd_left_nxt  = r_rd_left;
    w_smp_left_nxt = r_smp_left;
    w_err_nxt      = r_err;
`endif

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_addr_nxt = base_addr;
          w_left_nxt = length;
`ifdef LUT_LOADER_VERIFY_EN
          w_base_nxt  = base_addr;
          w_len_nxt   = length;
          w_sum_w_nxt = {DATA_W{1'b0}};
          w_sum_r_nxt = {DATA_W{1'b0}};
          w_err_nxt   = 1'b0;
`endif
          if (length == C_LEN_ZERO) begin
            // An empty load completes at once without touching the BRAM.
            w_state_nxt = S_FINISH;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt   = S_WRITE;
            w_busy_nxt    = 1'b1;
            w_s_ready_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_WRITE: begin
        if (w_accept) begin
          w_ena_nxt   = 1'b1;
          w_wea_nxt   = 1'b1;
          w_addra_nxt = r_addr;
          w_dina_nxt  = lut_bus.s_data;
          w_addr_nxt  = r_addr + C_ADDR_ONE;
          w_left_nxt  = r_left - C_LEN_ONE;
`ifdef LUT_LOADER_VERIFY_EN
          w_sum_w_nxt = f_sum_add(r_sum_w, lut_bus.s_data);
`endif
          // Drop ready together with the last accepted beat so no extra
          // byte can be taken.
          if (r_left == C_LEN_ONE) begin
            w_s_ready_nxt = 1'b0;
          end else begin
            w_s_ready_nxt = 1'b1;
          end
        end else if (r_left == C_LEN_ZERO) begin
          // The final write strobe is on the bus this cycle.
`ifdef LUT_LOADER_VERIFY_EN
          w_state_nxt    = S_VERIFY;
          w_ena_nxt      = 1'b1;
          w_wea_nxt      = 1'b0;
          w_addra_nxt    = r_base;
          w_addr_nxt     = r_base + C_ADDR_ONE;
          w_rd_left_nxt  = r_len - C_LEN_ONE;
          w_smp_left_nxt = r_len;
`else
          w_state_nxt = S_FINISH;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
`endif
        end else begin
          w_state_nxt = S_WRITE;
        end
      end

`ifdef LUT_LOADER_VERIFY_EN
      S_VERIFY: begin
        if (r_rd_left != C_LEN_ZERO) begin
          w_ena_nxt     = 1'b1;
          w_wea_nxt     = 1'b0;
          w_addra_nxt   = r_addr;
          w_addr_nxt    = r_addr + C_ADDR_ONE;
          w_rd_left_nxt = r_rd_left - C_LEN_ONE;
        end else begin
          w_ena_nxt = 1'b0;
        end
        if (r_rd_pipe[READ_LATENCY-1]) begin
          w_sum_r_nxt    = f_sum_add(r_sum_r, lut_bus.douta);
          w_smp_left_nxt = r_smp_left - C_LEN_ONE;
          if (r_smp_left == C_LEN_ONE) begin
            w_state_nxt = S_FINISH;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_err_nxt   = (f_sum_add(r_sum_r, lut_bus.douta) != r_sum_w);
          end else begin
            w_state_nxt = S_VERIFY;
          end
        end else begin
          w_state_nxt = S_VERIFY;
        end
      end
`endif

      S_FINISH: begin
        w_state_nxt   = S_IDLE;
        w_busy_nxt    = 1'b0;
        w_s_ready_nxt = 1'b0;
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_busy_nxt    = 1'b0;
        w_s_ready_nxt = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs and datapath counters.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_s_ready <= 1'b0;
      r_ena     <= 1'b0;
      r_wea     <= 1'b0;
      r_addra   <= {ADDR_W{1'b0}};
      r_dina    <= {DATA_W{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_addr    <= {ADDR_W{1'b0}};
      r_left    <= C_LEN_ZERO;
    end else begin
      r_s_ready <= w_s_ready_nxt;
      r_ena     <= w_ena_nxt;
      r_wea     <= w_wea_nxt;
      r_addra   <= w_addra_nxt;
      r_dina    <= w_dina_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_addr    <= w_addr_nxt;
      r_left    <= w_left_nxt;
    end
  end

`ifdef LUT_LOADER_VERIFY_EN
  // Verify bookkeeping: captured range, both checksums, and read counters.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_base     <= {ADDR_W{1'b0}};
      r_len      <= C_LEN_ZERO;
      r_sum_w    <= {DATA_W{1'b0}};
      r_sum_r    <= {DATA_W{1'b0}};
      r_rd_left  <= C_LEN_ZERO;
      r_smp_left <= C_LEN_ZERO;
      r_err      <= 1'b0;
    end else begin
      r_base     <= w_base_nxt;
      r_len      <= w_len_nxt;
      r_sum_w    <= w_sum_w_nxt;
      r_sum_r    <= w_sum_r_nxt;
      r_rd_left  <= w_rd_left_nxt;
      r_smp_left <= w_smp_left_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Delay line that marks when each read strobe's data appears on douta.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_rd_pipe <= {READ_LATENCY{1'b0}};
    end else begin
      r_rd_pipe[0] <= r_ena & ~r_wea;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign lut_bus.s_ready = r_s_ready;
  assign lut_bus.ena     = r_ena;
  assign lut_bus.wea     = r_wea;
  assign lut_bus.addra   = r_addra;
  assign lut_bus.dina    = r_dina;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule

// File: doc/bram_lut_loader.md
Name: bram_lut_loader

Overview:
- Write-side counterpart to the LUT read path: accepts a byte stream over a valid/ready handshake and writes it sequentially into the single-port 8-bit x 256 block RAM.
- Sits between a byte source (UART/host loader) and the BRAM port A; after loading, the LUT is read back by the existing read logic.
- Reports completion, and with the optional feature, a read-back checksum result.

Parameters:
- ADDR_W, 8, BRAM address width (depth 2**ADDR_W).
- DATA_W, 8, BRAM data and stream byte width.
- READ_LATENCY, 1, cycles from a read strobe (ena=1, wea=0) to valid douta; used only by the optional feature; legal values 1..2.

Ports:
- CLK100MHZ  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first BRAM address written; captured on start.
- length  in  ADDR_W+1  number of bytes to load, 0..256; captured on start.
- s_valid  in  1  source byte valid.
- s_data  in  DATA_W  source byte.
- s_ready  out  1  loader can accept a byte this cycle.
- ena  out  1  BRAM port enable.
- wea  out  1  BRAM write enable.
- addra  out  ADDR_W  BRAM address.
- dina  out  DATA_W  BRAM write data.
- douta  in  DATA_W  BRAM read data; used only with the optional feature.
- busy  out  1  load in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  checksum mismatch flag; constant 0 without the optional feature.

Behaviour:
- Reset is asynchronous and active-high. Every output goes to 0 (s_ready, ena, wea, addra, dina, busy, done, err), state returns to IDLE, counters clear.
- Reset mid-load abandons the load. Bytes already written stay in the BRAM and are not rolled back.
- All outputs are registered.
- IDLE state:
  - start=1 with length>0: capture base_addr and length, go to WRITE. busy=1 and s_ready=1 from the next cycle.
  - start=1 with length=0: go to FINISH; no BRAM access.
- WRITE state:
  - A beat transfers on a cycle with s_valid&s_ready.
  - The cycle after the transfer: ena=1, wea=1, addra=current address, dina=byte. Write latency is 1 cycle.
  - Cycles with no transfer: ena=0, wea=0; addra and dina hold their values.
  - The address increments by 1 per beat and wraps 255->0 (modulo 2**ADDR_W).
  - s_ready deasserts in the same registered update that accepts the final beat, so at most length beats are ever accepted.
  - After the final write strobe, go to FINISH.
  - s_valid may stall arbitrarily; no timeout.
- FINISH state: done=1 for exactly one cycle, busy=0 from that cycle, then return to IDLE.
- start while not in IDLE is ignored.
- Back-to-back loads are allowed: start may be asserted in the cycle after done.

Optional Feature:
- Macro: LUT_LOADER_VERIFY_EN.
- Defined:
  - During WRITE, keep an 8-bit modulo-256 sum of accepted bytes.
  - After the final write, enter VERIFY instead of FINISH. Issue one read per cycle (ena=1, wea=0), addresses base_addr..base_addr+length-1 with wrap.
  - Accumulate a second modulo-256 sum of douta, each sample taken READ_LATENCY cycles after its strobe.
  - When the last sample is in, go to FINISH. err=1 if the sums differ, else 0.
  - err holds its value until the next start (cleared on start) or reset.
  - busy stays high through VERIFY. length=0 skips VERIFY; err=0.
- Not defined: no VERIFY state, douta unused, err tied to 0, no sum logic synthesised.

Test Plan:
- Basic load: reset, start with base_addr=0x00, length=4, stream 0x11,0x22,0x33,0x44 with s_valid held high -> four write strobes, each one cycle after its beat, at addra 0..3 with matching dina; done pulses once; busy low afterwards; BRAM read of 0..3 returns the bytes.
- Stalled source: base=0x10, length=3, insert a 2-cycle s_valid gap between beats -> ena/wea low during the gaps; addresses 0x10,0x11,0x12; after the third beat s_ready=0 and a fourth s_valid is not accepted.
- Wrap and zero length: base=0xFE, length=3 -> writes at 0xFE,0xFF,0x00. Then start with length=0 -> done one cycle after start, no ena pulse.
- Ignored start and reset mid-load: pulse start during WRITE -> no change to captured parameters. Assert reset after 2 of 5 beats -> all outputs 0 immediately; addresses 0,1 hold data; a new load then works normally.
- Verify (LUT_LOADER_VERIFY_EN): load 0x01,0x02,0x03 at base 0x20 -> reads 0x20..0x22 follow, err=0 at done. Repeat with a bench model that corrupts douta at 0x21 -> err=1 at done, cleared by the next start.
